// File: rtl/mem_result_collector_if.sv
// mem_result_collector_if: host output stream between the result collector and the output arbiter
interface mem_result_collector_if #(
    parameter int LANES = 2
);
    logic                 output_request;
    logic                 output_permit;
    logic [LANES*256-1:0] output_data;
    logic                 output_valid;
    logic                 output_ready;
    logic                 output_finish;
    modport master (output output_request, output_data, output_valid, output_finish, input output_permit, output_ready);
    modport slave (input output_request, output_data, output_valid, output_finish, output output_permit, output_ready);
endinterface

// File: rtl/mem_result_collector.sv
// mem_result_collector: per-batch MEM result store streaming one header beat plus LANES-packed entry beats per read
module mem_result_collector #(
    parameter int READ_NUM_WIDTH = 9,
    parameter int MAX_READ = 512,
    parameter int MEM_DEPTH = 20,
    parameter int LANES = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      stall,
    input  logic [READ_NUM_WIDTH:0]   batch_size,
    input  logic                      mem_we,
    input  logic [READ_NUM_WIDTH-1:0] mem_read_num,
    input  logic [6:0]                mem_addr,
    input  logic [255:0]              mem_data,
    input  logic                      mem_size_valid,
    input  logic [6:0]                mem_size,
    input  logic [READ_NUM_WIDTH-1:0] mem_size_read_num,
    input  logic                      ret_valid,
    input  logic [6:0]                ret,
    input  logic [READ_NUM_WIDTH-1:0] ret_read_num,
    mem_result_collector_if.master    host,
    output logic                      overflow
);
    localparam int AW = $clog2(MAX_READ * MEM_DEPTH);
    localparam logic [6:0] DEPTH7 = 7'(MEM_DEPTH);
    localparam logic [READ_NUM_WIDTH:0] R1 = (READ_NUM_WIDTH+1)'(1);
    typedef enum logic [1:0] {IDLE, HDR, DATA, FIN} state_t;

    logic [112:0] ram_q [MAX_READ*MEM_DEPTH];
    logic [6:0] size_ram_q [MAX_READ];
    logic [6:0] ret_ram_q [MAX_READ];
    logic [112:0] lane_q [LANES];
    state_t state_q, state_d;
    logic [READ_NUM_WIDTH:0] rd_q, rd_d, done_q, done_d;
    logic [6:0] ent_q, ent_d;
    logic [MAX_READ-1:0] seen_q, seen_d, aovf_q, aovf_d;
    logic ovf_q, ovf_d, req_q, req_d, fin_q, fin_d, wv_q, wv_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [112:0] wd_q, wd_d;
    logic s1v_q, s1v_d, s1h_q, s1h_d, s1o_q, s1o_d, ov_q, ov_d;
    logic [READ_NUM_WIDTH-1:0] s1r_q, s1r_d, ri;
    logic [6:0] s1s_q, s1s_d, s1t_q, s1t_d, cur_raw, cur_sz;
    logic [LANES-1:0] s1e_q, s1e_d;
    logic [LANES*256-1:0] od_q, od_d, beat;
    logic frozen, issue, last_rd, last_ent, unused_bits;

    // Compacted 113-bit entry back to its 256-bit slot, dropped bits zero
    function automatic logic [255:0] expand(logic [112:0] c);
        logic [255:0] e;
        e = '0;
        e[230:224] = c[112:106];
        e[198:192] = c[105:99];
        e[160:128] = c[98:66];
        e[96:64] = c[65:33];
        e[32:0] = c[32:0];
        return e;
    endfunction

    assign unused_bits = ^{mem_data[255:231], mem_data[223:199], mem_data[191:161], mem_data[127:97], mem_data[63:33]};
    assign host.output_request = req_q;
    assign host.output_data = od_q;
    assign host.output_valid = ov_q;
    assign host.output_finish = fin_q;
    assign overflow = ovf_q;

    // Pipeline freeze and lookups for the read currently being walked
    always_comb begin
        frozen = stall || (ov_q && !host.output_ready);
        issue = !frozen && host.output_permit && (state_q == HDR || state_q == DATA);
        ri = rd_q[READ_NUM_WIDTH-1:0];
        cur_raw = size_ram_q[ri];
        cur_sz = cur_raw > DEPTH7 ? DEPTH7 : cur_raw;
        last_rd = rd_q + R1 == batch_size;
        last_ent = {1'b0, ent_q} + 8'(LANES) >= {1'b0, cur_sz};
    end

    // FSM: per read one header fetch, then ceil(size/LANES) data fetches
    always_comb begin
        state_d = state_q;
        rd_d = rd_q;
        ent_d = ent_q;
        if (state_q == IDLE && req_q && host.output_permit && !stall) begin
            state_d = HDR;
            rd_d = '0;
            ent_d = '0;
        end else if (issue && state_q == HDR && cur_sz != '0) begin
            state_d = DATA;
            ent_d = '0;
        end else if (issue && (state_q == HDR || last_ent)) begin
            rd_d = rd_q + R1;
            ent_d = '0;
            state_d = last_rd ? FIN : HDR;
        end else if (issue) begin
            ent_d = ent_q + 7'(LANES);
        end
    end

    // Fetch stage: header fields and lane-valid mask travel alongside the RAM read
    always_comb begin
        {s1v_d, s1h_d, s1o_d, s1r_d, s1s_d, s1t_d, s1e_d} = {s1v_q, s1h_q, s1o_q, s1r_q, s1s_q, s1t_q, s1e_q};
        if (!frozen) begin
            s1v_d = issue;
            s1h_d = state_q == HDR;
            s1r_d = ri;
            s1s_d = cur_raw;
            s1t_d = ret_ram_q[ri];
            s1o_d = aovf_q[ri] || cur_raw > DEPTH7;
            for (int l = 0; l < LANES; l++) s1e_d[l] = {1'b0, ent_q} + 8'(l) < {1'b0, cur_sz};
        end
    end

    // Output stage: build the header or packed data beat and hold it under freeze
    always_comb begin
        beat = '0;
        if (s1h_q) begin
            beat[READ_NUM_WIDTH-1:0] = s1r_q;
            beat[70:64] = s1s_q;
            beat[134:128] = s1t_q;
            beat[192] = s1o_q;
        end else begin
            for (int l = 0; l < LANES; l++) beat[l*256 +: 256] = s1e_q[l] ? expand(lane_q[l]) : '0;
        end
        ov_d = frozen ? ov_q : s1v_q;
        od_d = !frozen && s1v_q ? beat : od_q;
    end

    // Write staging, size/seen bookkeeping, overflow, request and finish
    always_comb begin
        {wv_d, wa_d, wd_d, seen_d, aovf_d, done_d, ovf_d, req_d, fin_d} = {wv_q, wa_q, wd_q, seen_q, aovf_q, done_q, ovf_q, req_q, fin_q};
        if (!stall) begin
            wv_d = mem_we && mem_addr < DEPTH7;
            wa_d = AW'(mem_read_num) * AW'(MEM_DEPTH) + AW'(mem_addr);
            wd_d = {mem_data[230:224], mem_data[198:192], mem_data[160:128], mem_data[96:64], mem_data[32:0]};
            if (mem_we && mem_addr >= DEPTH7) begin
                aovf_d[mem_read_num] = 1'b1;
                ovf_d = 1'b1;
            end
            if (mem_size_valid && mem_size > DEPTH7) ovf_d = 1'b1;
            if (mem_size_valid && !seen_q[mem_size_read_num]) begin
                seen_d[mem_size_read_num] = 1'b1;
                done_d = done_q + R1;
            end
            fin_d = fin_q || (!frozen && state_q == FIN && !s1v_q);
            req_d = !fin_d && (req_q || (done_q == batch_size && batch_size != '0));
        end
    end

    // Control and pipeline registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            {rd_q, done_q, ent_q, seen_q, aovf_q, ovf_q, req_q, fin_q} <= '0;
            {wv_q, wa_q, wd_q} <= '0;
            {s1v_q, s1h_q, s1o_q, s1r_q, s1s_q, s1t_q, s1e_q} <= '0;
            {ov_q, od_q} <= '0;
        end else begin
            state_q <= state_d;
            {rd_q, done_q, ent_q, seen_q, aovf_q, ovf_q, req_q, fin_q} <= {rd_d, done_d, ent_d, seen_d, aovf_d, ovf_d, req_d, fin_d};
            {wv_q, wa_q, wd_q} <= {wv_d, wa_d, wd_d};
            {s1v_q, s1h_q, s1o_q, s1r_q, s1s_q, s1t_q, s1e_q} <= {s1v_d, s1h_d, s1o_d, s1r_d, s1s_d, s1t_d, s1e_d};
            {ov_q, od_q} <= {ov_d, od_d};
        end
    end

    // Entry, size and ret queues plus the registered lane reads
    always_ff @(posedge clk) begin
        if (!stall && wv_q) ram_q[wa_q] <= wd_q;
        if (!stall && mem_size_valid) size_ram_q[mem_size_read_num] <= mem_size;
        if (!stall && ret_valid) ret_ram_q[ret_read_num] <= ret;
        if (!frozen) begin
            for (int l = 0; l < LANES; l++)
                lane_q[l] <= ram_q[{1'b0, ent_q} + 8'(l) < {1'b0, DEPTH7} ? AW'(ri) * AW'(MEM_DEPTH) + AW'(ent_q) + AW'(l) : AW'(0)];
        end
    end
endmodule

// File: tb/tb_mem_result_collector.sv
// tb_mem_result_collector: directed checks of batching, streaming, backpressure, stall, overflow and reset
module tb_mem_result_collector;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic stall = 1'b0;
    logic [9:0] batch_size = '0;
    logic mem_we = 1'b0;
    logic [8:0] mem_read_num = '0;
    logic [6:0] mem_addr = '0;
    logic [255:0] mem_data = '0;
    logic mem_size_valid = 1'b0;
    logic [6:0] mem_size = '0;
    logic [8:0] mem_size_read_num = '0;
    logic ret_valid = 1'b0;
    logic [6:0] ret = '0;
    logic [8:0] ret_read_num = '0;
    logic overflow;
    int n_chk = 0;
    int n_fail = 0;
    logic [255:0] ea [20];
    logic [255:0] a0, a1, a2, junk;

    mem_result_collector_if #(.LANES(2)) h ();

    mem_result_collector dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .batch_size(batch_size),
        .mem_we(mem_we), .mem_read_num(mem_read_num), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_size_valid(mem_size_valid), .mem_size(mem_size), .mem_size_read_num(mem_size_read_num),
        .ret_valid(ret_valid), .ret(ret), .ret_read_num(ret_read_num),
        .host(h), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] keep(logic [255:0] d);
        logic [255:0] m;
        m = '0;
        m[230:224] = '1;
        m[198:192] = '1;
        m[160:128] = '1;
        m[96:64] = '1;
        m[32:0] = '1;
        return d & m;
    endfunction

    function automatic logic [511:0] pack(logic [255:0] lo, logic [255:0] hi);
        return {keep(hi), keep(lo)};
    endfunction

    function automatic logic [511:0] hdr(int idx, int sz, int rv, bit o);
        logic [511:0] b;
        b = '0;
        b[8:0] = 9'(idx);
        b[70:64] = 7'(sz);
        b[159:128] = 32'(rv);
        b[192] = o;
        return b;
    endfunction

    function automatic logic [255:0] rnd();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input int r, input int a, input logic [255:0] d);
        mem_we = 1'b1;
        mem_read_num = 9'(r);
        mem_addr = 7'(a);
        mem_data = d;
        tick();
        mem_we = 1'b0;
    endtask

    task automatic sz(input int r, input int s);
        mem_size_valid = 1'b1;
        mem_size_read_num = 9'(r);
        mem_size = 7'(s);
        tick();
        mem_size_valid = 1'b0;
    endtask

    task automatic rt(input int r, input int v);
        ret_valid = 1'b1;
        ret_read_num = 9'(r);
        ret = 7'(v);
        tick();
        ret_valid = 1'b0;
    endtask

    task automatic take(input string tag, input logic [511:0] exp);
        chk({tag, "_valid"}, 512'(h.output_valid), 512'(1));
        chk(tag, h.output_data, exp);
        tick();
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !h.output_valid; i++) tick();
        chk({tag, "_start"}, 512'(h.output_valid), 512'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        h.output_permit = 1'b0;
        h.output_ready = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        chk("rst_request", 512'(h.output_request), 512'(0));
        chk("rst_valid", 512'(h.output_valid), 512'(0));
        chk("rst_finish", 512'(h.output_finish), 512'(0));
        chk("rst_overflow", 512'(overflow), 512'(0));
        chk("rst_data", h.output_data, 512'(0));

        // batch A: read0 size 3 ret 5, read1 size 0 ret 9, stalled write, duplicate size
        batch_size = 10'd2;
        a0 = rnd();
        a1 = rnd();
        a2 = rnd();
        junk = rnd();
        wr(0, 0, a0);
        mem_we = 1'b1;
        mem_read_num = 9'd0;
        mem_addr = 7'd1;
        mem_data = a1;
        tick();
        stall = 1'b1;
        mem_data = junk;
        repeat (3) tick();
        stall = 1'b0;
        mem_we = 1'b0;
        wr(0, 2, a2);
        rt(0, 5);
        rt(1, 9);
        sz(0, 3);
        sz(0, 3);
        tick();
        chk("a_dup_no_req", 512'(h.output_request), 512'(0));
        sz(1, 0);
        chk("a_req_not_yet", 512'(h.output_request), 512'(0));
        tick();
        chk("a_req_set", 512'(h.output_request), 512'(1));
        h.output_permit = 1'b1;
        tick();
        tick();
        chk("a_latency_early", 512'(h.output_valid), 512'(0));
        tick();
        take("a_hdr0", hdr(0, 3, 5, 0));
        take("a_d01", pack(a0, a1));
        take("a_d2", pack(a2, '0));
        take("a_hdr1", hdr(1, 0, 9, 0));
        chk("a_finish", 512'(h.output_finish), 512'(1));
        chk("a_fin_valid", 512'(h.output_valid), 512'(0));
        chk("a_fin_req", 512'(h.output_request), 512'(0));
        h.output_permit = 1'b0;

        // batch B: address overflow, size 30 clamped to 20, backpressure and stall mid-DATA
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("b_rst_finish", 512'(h.output_finish), 512'(0));
        batch_size = 10'd1;
        for (int i = 0; i < 20; i++) begin
            ea[i] = rnd();
            wr(0, i, ea[i]);
        end
        chk("b_no_ovf", 512'(overflow), 512'(0));
        wr(0, 25, rnd());
        chk("b_ovf_addr", 512'(overflow), 512'(1));
        rt(0, 7);
        sz(0, 30);
        tick();
        h.output_permit = 1'b1;
        wait_valid("b");
        take("b_hdr", hdr(0, 30, 7, 1));
        for (int k = 0; k < 3; k++) take($sformatf("b_d%0d", k), pack(ea[2*k], ea[2*k+1]));
        h.output_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b_bp_valid", 512'(h.output_valid), 512'(1));
            chk("b_bp_data", h.output_data, pack(ea[6], ea[7]));
        end
        h.output_ready = 1'b1;
        take("b_d3", pack(ea[6], ea[7]));
        take("b_d4", pack(ea[8], ea[9]));
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b_stall_valid", 512'(h.output_valid), 512'(1));
            chk("b_stall_data", h.output_data, pack(ea[10], ea[11]));
        end
        stall = 1'b0;
        for (int k = 5; k < 10; k++) take($sformatf("b_d%0d", k), pack(ea[2*k], ea[2*k+1]));
        chk("b_finish", 512'(h.output_finish), 512'(1));
        chk("b_fin_valid", 512'(h.output_valid), 512'(0));

        // batch C: size overflow, then reset in the middle of the stream
        h.output_permit = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("c_rst_ovf_clear", 512'(overflow), 512'(0));
        sz(0, 21);
        rt(0, 3);
        tick();
        chk("c_ovf_size", 512'(overflow), 512'(1));
        h.output_permit = 1'b1;
        wait_valid("c");
        take("c_hdr", hdr(0, 21, 3, 1));
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("c_abort_valid", 512'(h.output_valid), 512'(0));
        chk("c_abort_finish", 512'(h.output_finish), 512'(0));
        chk("c_abort_ovf", 512'(overflow), 512'(0));
        chk("c_abort_req", 512'(h.output_request), 512'(0));

        // batch D: clean restart after the abort
        batch_size = 10'd2;
        a0 = rnd();
        a1 = rnd();
        a2 = rnd();
        wr(0, 0, a0);
        wr(0, 1, a1);
        wr(1, 0, a2);
        rt(0, 4);
        rt(1, 6);
        sz(0, 2);
        sz(1, 1);
        wait_valid("d");
        take("d_hdr0", hdr(0, 2, 4, 0));
        take("d_d01", pack(a0, a1));
        take("d_hdr1", hdr(1, 1, 6, 0));
        take("d_d2", pack(a2, '0));
        chk("d_finish", 512'(h.output_finish), 512'(1));
        chk("d_fin_valid", 512'(h.output_valid), 512'(0));
        tick();
        chk("d_finish_sticky", 512'(h.output_finish), 512'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_result_collector.md
Name: mem_result_collector

Overview:
- Parametrised successor of the per-batch SMEM result store in the SMEM pipeline.
- Stores each read's MEM entries, final mem_size and ret into on-chip queues.
- After every read in the batch has reported its size, it streams per-read groups to the host output arbiter: one header beat, then MEM entries packed LANES per beat.
- New relative to the previous generation: configurable depth and lane count, ready/valid backpressure, overflow detection, duplicate-size filtering, gapless streaming.

Parameters:
READ_NUM_WIDTH, 9, width of read index.
MAX_READ, 512, reads per batch (≤ 2^READ_NUM_WIDTH).
MEM_DEPTH, 20, MEM slots per read (≤ 127).
LANES, 2, MEM entries per output beat (1, 2 or 4); one output beat = LANES*256 bits.

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
stall  in  1  global pipeline stall; all state holds while 1
batch_size  in  READ_NUM_WIDTH+1  reads in current batch
mem_we  in  1  MEM entry write strobe
mem_read_num  in  READ_NUM_WIDTH  read owning entry
mem_addr  in  7  slot index within read
mem_data  in  256  entry {info, x2, x1, x0} slot format
mem_size_valid  in  1  final MEM count strobe
mem_size  in  7  MEM count for read
mem_size_read_num  in  READ_NUM_WIDTH  read index
ret_valid  in  1  ret strobe
ret  in  7  ret value
ret_read_num  in  READ_NUM_WIDTH  read index
output_request  out  1  batch ready to stream
output_permit  in  1  arbiter grant, level
output_data  out  LANES*256  beat
output_valid  out  1  beat valid
output_ready  in  1  sink accepts beat
output_finish  out  1  batch fully streamed (sticky)
overflow  out  1  sticky: write or size exceeded MEM_DEPTH

Behaviour:
- Clock is clk; reset is synchronous active-low on reset_n, sampled at the clk edge.
- Reset values: output_request=0, output_valid=0, output_finish=0, overflow=0, output_data=0. Reset also clears the FSM, the pointers and the size-seen bitmap.
- A reset while streaming aborts the stream; the next beat after reset is not valid.
- stall=1: no write or read takes effect and every register holds. This includes a presented beat.
- Entry compaction (113 bits kept): data bits [230:224], [198:192], [160:128], [96:64], [32:0]. Expansion on output zero-fills all other bits of each 256-bit slot.
- Write path: one register stage, then RAM address read_num*MEM_DEPTH+mem_addr.
- A write with mem_addr ≥ MEM_DEPTH is dropped and sets overflow.
- mem_size > MEM_DEPTH: the stored value is clamped to MEM_DEPTH, overflow is set, and the header carries the unclamped value.
- A write and a stream read in the same cycle are both served; writes arriving after output_request=1 are undefined.
- Size tracking: a per-read seen bit. Only the first mem_size_valid for a read increments done_count. Later strobes overwrite the size but do not count.
- ret_valid writes the ret queue unconditionally.
- output_request=1 from the cycle after done_count==batch_size with batch_size>0. It stays high until output_finish.
- FSM states: IDLE → (request && permit) → HDR → DATA → HDR (next read) … → FIN.
  - HDR beat layout: [READ_NUM_WIDTH-1:0]=read index, [70:64]=mem_size, [159:128]=zero-extended ret, [192]=that read's overflow; all other bits 0.
  - DATA: ceil(size/LANES) beats, entry k in lane k mod LANES, unused lanes of the last beat are 0.
  - Size 0: HDR only, no DATA.
  - After the last read: FIN, output_finish=1, output_valid=0.
- Handshake: a beat transfers when output_valid && output_ready && !stall.
- Backpressure: output_valid && !output_ready freezes the whole fetch pipeline. output_data must stay stable.
- Permit dropped: no new beat is launched, but a beat already presented stays valid until accepted.
- Latency: the first HDR beat appears 3 cycles after the first cycle with permit=1 and request=1 (RAM read 1 + register 2).
- Throughput: one beat per cycle, with no gap beats between reads.
- Pointers: the in-read entry counter steps by LANES. The read pointer advances to the next read after that read's last DATA beat (or after HDR if size is 0).

Test Plan:
- LANES=2, batch_size=2: read0 size 3, ret 5; read1 size 0. Expect beats HDR0(size3, ret5), {e0,e1}, {e2,0}, HDR1(size0), then finish=1 with no gaps.
- Hold output_ready=0 for 4 cycles mid-DATA → output_data unchanged and no beat lost or duplicated; stream resumes in order.
- Duplicate mem_size_valid for read 0 with batch_size=2 → output_request stays 0 until read 1 also reports its size.
- mem_addr=25 with MEM_DEPTH=20 → write dropped, overflow=1. mem_size=30 → header shows 30, 20 entries streamed.
- stall=1 for 3 cycles during streaming, and during a write → no state change, identical beat sequence afterwards.
- reset_n=0 mid-stream, then a new batch → clean restart: output_finish=0, first beat is HDR of read 0, overflow cleared.
